// File: rtl/multi_cycle_ctrl_if.sv
// Control/datapath bundle for the multi-cycle CPU controller.
// The controller drives the master side; the datapath (and the debug
// display) sit on the slave side.
interface multi_cycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic [2:0] state;
    logic       PCWre;
    logic       IRWre;
    logic       InsMemRW;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       ALUSrcA;
    logic       ALUSrcB;
    logic       ExtSel;
    logic [2:0] ALUOp;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
    logic [1:0] PCSrc;
    logic       illegal;
    logic       halted;

    modport master (
        input  opcode, zero, sign,
        output state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, DBDataSrc, mRD, mWR,
               PCSrc, illegal, halted
    );

    modport slave (
        output opcode, zero, sign,
        input  state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc,
               ALUSrcA, ALUSrcB, ExtSel, ALUOp, DBDataSrc, mRD, mWR,
               PCSrc, illegal, halted
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: IF/ID/EXE/MEM/WB sequencer for the multi-cycle CPU.
// State and the sticky halt flag are registered; all datapath controls
// are decoded combinationally from state, opcode, zero and sign.
// Optional feature macro: CTRL_JAL_JR_EN (decode jal/jr; otherwise
// those opcodes fall through as illegal 2-cycle nops).
module multi_cycle_ctrl (
    input logic               CLK,
    input logic               RST,
    multi_cycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    state_t state;
    logic   halted;

    logic [5:0] op;
    assign op = bus.opcode;

    // Opcode decode classes.
    logic is_rtype, is_itype, is_alu, is_lw, is_sw, is_br;
    logic is_j, is_jr, is_jal, is_halt, is_illegal;
    logic [2:0] alu_op;
    logic       alu_ext;

    // Classify the opcode held in IR.
    always_comb begin
        is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLL);
        is_itype = (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
        is_alu   = is_rtype || is_itype;
        is_lw    = (op == OP_LW);
        is_sw    = (op == OP_SW);
        is_br    = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
        is_j     = (op == OP_J);
`ifdef CTRL_JAL_JR_EN
        is_jr    = (op == OP_JR);
        is_jal   = (op == OP_JAL);
`else
        is_jr    = 1'b0;
        is_jal   = 1'b0;
`endif
        is_halt  = (op == OP_HALT);
        is_illegal = !(is_alu || is_lw || is_sw || is_br || is_j || is_jr || is_jal || is_halt);

        case (op)
            OP_SUB:             alu_op = ALU_SUB;
            OP_AND, OP_ANDI:    alu_op = ALU_AND;
            OP_ORI:             alu_op = ALU_OR;
            OP_SLL:             alu_op = ALU_SLL;
            OP_SLTI:            alu_op = ALU_SLT;
            default:            alu_op = ALU_ADD;
        endcase
        // Logical immediates zero-extend, everything else sign-extends.
        alu_ext = !((op == OP_ANDI) || (op == OP_ORI));
    end

    // State sequencing and the sticky halt flag; halt parks the FSM in IF.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IF;
            halted <= 1'b0;
        end else if (halted) begin
            state  <= S_IF;
        end else begin
            case (state)
                S_IF: state <= S_ID;
                S_ID: begin
                    if (is_halt) begin
                        halted <= 1'b1;
                        state  <= S_IF;
                    end else if (is_br)         state <= S_EXE_BR;
                    else if (is_lw || is_sw)    state <= S_EXE_LS;
                    else if (is_alu)            state <= S_EXE_AL;
                    else                        state <= S_IF;
                end
                S_EXE_AL: state <= S_WB_AL;
                S_WB_AL:  state <= S_IF;
                S_EXE_BR: state <= S_IF;
                S_EXE_LS: state <= S_MEM;
                S_MEM:    state <= is_lw ? S_WB_LD : S_IF;
                S_WB_LD:  state <= S_IF;
                default:  state <= S_IF;
            endcase
        end
    end

    logic       pc_wre, ir_wre, ins_rd, reg_wre, wr_src, src_a, src_b, ext_sel;
    logic       db_src, m_rd, m_wr, illegal;
    logic [1:0] reg_dst, pc_src;
    logic [2:0] alu_sel;

    // Datapath controls; everything idles to 0 under reset or halt.
    always_comb begin
        pc_wre  = 1'b0;
        ir_wre  = 1'b0;
        ins_rd  = 1'b0;
        reg_wre = 1'b0;
        reg_dst = 2'b00;
        wr_src  = 1'b0;
        src_a   = 1'b0;
        src_b   = 1'b0;
        ext_sel = 1'b0;
        alu_sel = ALU_ADD;
        db_src  = 1'b0;
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        pc_src  = 2'b00;
        illegal = 1'b0;
        if (!RST && !halted) begin
            case (state)
                S_IF: begin
                    ins_rd = 1'b1;
                    ir_wre = 1'b1;
                end
                S_ID: begin
                    if (is_j) begin
                        pc_wre = 1'b1;
                        pc_src = 2'b11;
                    end else if (is_jr) begin
                        pc_wre = 1'b1;
                        pc_src = 2'b10;
                    end else if (is_jal) begin
                        pc_wre  = 1'b1;
                        pc_src  = 2'b11;
                        reg_wre = 1'b1;
                    end else if (is_illegal) begin
                        pc_wre  = 1'b1;
                        illegal = 1'b1;
                    end
                end
                S_EXE_AL, S_WB_AL: begin
                    src_b   = is_itype;
                    src_a   = (op == OP_SLL);
                    ext_sel = alu_ext;
                    alu_sel = alu_op;
                    if (state == S_WB_AL) begin
                        reg_wre = 1'b1;
                        wr_src  = 1'b1;
                        reg_dst = is_rtype ? 2'b10 : 2'b01;
                        pc_wre  = 1'b1;
                    end
                end
                S_EXE_BR: begin
                    alu_sel = ALU_SUB;
                    ext_sel = 1'b1;
                    pc_wre  = 1'b1;
                    case (op)
                        OP_BEQ:  pc_src = bus.zero  ? 2'b01 : 2'b00;
                        OP_BNE:  pc_src = !bus.zero ? 2'b01 : 2'b00;
                        OP_BLTZ: pc_src = bus.sign  ? 2'b01 : 2'b00;
                        default: pc_src = 2'b00;
                    endcase
                end
                S_EXE_LS, S_MEM: begin
                    src_b   = 1'b1;
                    ext_sel = 1'b1;
                    if (state == S_MEM) begin
                        m_wr   = is_sw;
                        m_rd   = is_lw;
                        pc_wre = is_sw;
                    end
                end
                S_WB_LD: begin
                    m_rd    = 1'b1;
                    db_src  = 1'b1;
                    reg_wre = 1'b1;
                    reg_dst = 2'b01;
                    wr_src  = 1'b1;
                    pc_wre  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state     = state;
    assign bus.halted    = halted;
    assign bus.PCWre     = pc_wre;
    assign bus.IRWre     = ir_wre;
    assign bus.InsMemRW  = ins_rd;
    assign bus.RegWre    = reg_wre;
    assign bus.RegDst    = reg_dst;
    assign bus.WrRegDSrc = wr_src;
    assign bus.ALUSrcA   = src_a;
    assign bus.ALUSrcB   = src_b;
    assign bus.ExtSel    = ext_sel;
    assign bus.ALUOp     = alu_sel;
    assign bus.DBDataSrc = db_src;
    assign bus.mRD       = m_rd;
    assign bus.mWR       = m_wr;
    assign bus.PCSrc     = pc_src;
    assign bus.illegal   = illegal;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class
// through its states and checks controls against hand-derived values.
module tb_multi_cycle_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   compared = 0;
    int   mismatched = 0;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    // {PCWre, IRWre, InsMemRW, RegWre, mWR, mRD}
    logic [5:0] en;
    assign en = {bus.PCWre, bus.IRWre, bus.InsMemRW, bus.RegWre, bus.mWR, bus.mRD};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;

        // Power-on reset
        RST = 1'b1;
        step(); step();
        chk("por_state", 32'(bus.state), 0);
        chk("por_halted", 32'(bus.halted), 0);
        chk("por_en", 32'(en), 0);
        RST = 1'b0; #1;
        chk("if_en", 32'(en), 32'b011000);

        // add: 000 -> 001 -> 110 -> 111 -> 000
        bus.opcode = 6'b000000;
        step(); chk("add_id_state", 32'(bus.state), 1);
        chk("add_id_en", 32'(en), 0);
        step(); chk("add_exe_state", 32'(bus.state), 6);
        chk("add_exe_en", 32'(en), 0);
        chk("add_exe_aluop", 32'(bus.ALUOp), 0);
        step(); chk("add_wb_state", 32'(bus.state), 7);
        chk("add_wb_en", 32'(en), 32'b100100);
        chk("add_wb_regdst", 32'(bus.RegDst), 2);
        chk("add_wb_wrsrc", 32'(bus.WrRegDSrc), 1);
        step(); chk("add_done_state", 32'(bus.state), 0);

        // lw to sMEM, then reset mid-instruction
        bus.opcode = 6'b110001;
        step(); step();
        chk("lw_exe_state", 32'(bus.state), 2);
        chk("lw_exe_srcb", 32'(bus.ALUSrcB), 1);
        chk("lw_exe_en", 32'(en), 0);
        step(); chk("lw_mem_state", 32'(bus.state), 3);
        chk("lw_mem_en", 32'(en), 32'b000001);
        RST = 1'b1; #1;
        chk("rst_mem_en", 32'(en), 0);
        chk("rst_mem_srcb", 32'(bus.ALUSrcB), 0);
        step(); chk("rst1_state", 32'(bus.state), 0);
        chk("rst1_en", 32'(en), 0);
        step(); chk("rst2_state", 32'(bus.state), 0);
        chk("rst2_halted", 32'(bus.halted), 0);
        RST = 1'b0; #1;
        chk("rst_if_irwre", 32'(bus.IRWre), 1);

        // full lw
        step(); step(); step();
        chk("lw2_mem_mrd", 32'(bus.mRD), 1);
        step(); chk("lw_wb_state", 32'(bus.state), 4);
        chk("lw_wb_en", 32'(en), 32'b100101);
        chk("lw_wb_dbsrc", 32'(bus.DBDataSrc), 1);
        chk("lw_wb_regdst", 32'(bus.RegDst), 1);
        step(); chk("lw_done_state", 32'(bus.state), 0);

        // sw
        bus.opcode = 6'b110000;
        step(); step(); step();
        chk("sw_mem_state", 32'(bus.state), 3);
        chk("sw_mem_en", 32'(en), 32'b100010);
        step(); chk("sw_done_state", 32'(bus.state), 0);

        // beq taken / not taken
        bus.opcode = 6'b110100; bus.zero = 1'b1;
        step(); step();
        chk("beq_state", 32'(bus.state), 5);
        chk("beq_t_pcsrc", 32'(bus.PCSrc), 1);
        chk("beq_pcwre", 32'(bus.PCWre), 1);
        chk("beq_aluop", 32'(bus.ALUOp), 1);
        bus.zero = 1'b0; #1;
        chk("beq_nt_pcsrc", 32'(bus.PCSrc), 0);
        step(); chk("beq_done_state", 32'(bus.state), 0);

        // bltz taken
        bus.opcode = 6'b110110; bus.sign = 1'b1;
        step(); step();
        chk("bltz_t_pcsrc", 32'(bus.PCSrc), 1);
        step(); bus.sign = 1'b0;

        // bne: zero=1 not taken, zero=0 taken
        bus.opcode = 6'b110101; bus.zero = 1'b1;
        step(); step();
        chk("bne_nt_pcsrc", 32'(bus.PCSrc), 0);
        bus.zero = 1'b0; #1;
        chk("bne_t_pcsrc", 32'(bus.PCSrc), 1);
        step();

        // ori: zero-extended immediate, OR, rt destination
        bus.opcode = 6'b010010;
        step(); step();
        chk("ori_exe_ctrl", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.ALUOp}), 32'b010011);
        step(); chk("ori_wb_regdst", 32'(bus.RegDst), 1);
        step();

        // sll: shamt on A
        bus.opcode = 6'b011000;
        step(); step();
        chk("sll_exe_ctrl", 32'({bus.ALUSrcA, bus.ALUSrcB, bus.ExtSel, bus.ALUOp}), 32'b101010);
        step(); step();

        // j: 2 cycles
        bus.opcode = 6'b111000;
        step(); chk("j_pcsrc", 32'(bus.PCSrc), 3);
        chk("j_en", 32'(en), 32'b100000);
        step(); chk("j_done_state", 32'(bus.state), 0);

        // undecoded opcode: 2-cycle nop
        bus.opcode = 6'b101010;
        step(); chk("ill_flag", 32'(bus.illegal), 1);
        chk("ill_en", 32'(en), 32'b100000);
        chk("ill_pcsrc", 32'(bus.PCSrc), 0);
        step(); chk("ill_done_state", 32'(bus.state), 0);

        // jal
        bus.opcode = 6'b111010;
        step();
`ifdef CTRL_JAL_JR_EN
        chk("jal_pcsrc", 32'(bus.PCSrc), 3);
        chk("jal_en", 32'(en), 32'b100100);
        chk("jal_regdst", 32'({bus.RegDst, bus.WrRegDSrc}), 0);
        chk("jal_illegal", 32'(bus.illegal), 0);
`else
        chk("jal_illegal", 32'(bus.illegal), 1);
        chk("jal_pcsrc", 32'(bus.PCSrc), 0);
        chk("jal_en", 32'(en), 32'b100000);
`endif
        step(); chk("jal_done_state", 32'(bus.state), 0);

        // halt
        bus.opcode = 6'b111111;
        step(); chk("halt_id_state", 32'(bus.state), 1);
        chk("halt_id_en", 32'(en), 0);
        step(); chk("halt_state", 32'(bus.state), 0);
        chk("halt_flag", 32'(bus.halted), 1);
        chk("halt_en", 32'(en), 0);
        bus.opcode = 6'b000000;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halted_hold", 32'({bus.state, en}), 0);
        end
        RST = 1'b1;
        step();
        RST = 1'b0; #1;
        chk("unhalt_flag", 32'(bus.halted), 0);
        chk("unhalt_irwre", 32'(bus.IRWre), 1);
        step(); chk("unhalt_state", 32'(bus.state), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Control-unit FSM for the board-level multi-cycle CPU. It sequences each instruction through the IF/ID/EXE/MEM/WB states. It drives every write-enable and mux-select of the datapath: PC register, IR, register file, ALU, data memory and DB mux. It also exposes its current state so the 7-segment debug wrapper can show it. It advances one state per rising edge of the debounced step clock.

## Interface
- No parameters.
- CLK  in  1  CPU clock (debounced single-step button in the board wrapper).
- RST  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]. Must be held stable by the IR from ID through the last state of the instruction.
- zero  in  1  ALU result == 0.
- sign  in  1  ALU result[31].
- state  out  3  current FSM state.
- PCWre  out  1  PC register load enable.
- IRWre  out  1  IR load enable.
- InsMemRW  out  1  instruction memory read.
- RegWre  out  1  register-file write.
- RegDst  out  2  write address: 00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  out  1  write data: 0 = PC+4, 1 = DB.
- ALUSrcA  out  1  A operand: 1 = shamt, 0 = rs.
- ALUSrcB  out  1  B operand: 1 = extended immediate, 0 = rt.
- ExtSel  out  1  extension mode: 1 = sign-extend, 0 = zero-extend.
- ALUOp  out  3  000 = add, 001 = sub, 010 = sll (B<<A), 011 = or, 100 = and, 110 = signed slt.
- DBDataSrc  out  1  DB source: 0 = ALU result, 1 = data memory.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- PCSrc  out  2  next PC: 00 = PC+4, 01 = PC+4+(imm<<2), 10 = rs, 11 = {PC+4[31:28], addr26, 00}.
- illegal  out  1  high in ID when the opcode is not decoded.
- halted  out  1  sticky halt flag.

## Operation
- State encodings:
  - sIF = 000
  - sID = 001
  - sEXE_LS = 010
  - sMEM = 011
  - sWB_LD = 100
  - sEXE_BR = 101
  - sEXE_AL = 110
  - sWB_AL = 111
- Decoded opcodes:
  - ALU group: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, sll 011000, slti 100111.
  - Memory: sw 110000, lw 110001.
  - Branches: beq 110100, bne 110101, bltz 110110.
  - Jumps: j 111000, jr 111001, jal 111010.
  - halt 111111.
- Transitions:
  - sIF → sID.
  - From sID:
    - j / jr / jal / halt / illegal → sIF.
    - Branches → sEXE_BR.
    - lw / sw → sEXE_LS.
    - ALU group → sEXE_AL.
  - sEXE_AL → sWB_AL → sIF.
  - sEXE_BR → sIF.
  - sEXE_LS → sMEM.
  - From sMEM: sw → sIF; lw → sWB_LD.
  - sWB_LD → sIF.
- Outputs are combinational from state, opcode, zero and sign. Every enable defaults to 0 and every select defaults to 0.
- sIF: InsMemRW = 1 and IRWre = 1.
- PCWre = 1 only in the last state of each instruction:
  - ID for j, jr, jal and illegal;
  - sWB_AL;
  - sEXE_BR;
  - sMEM for sw;
  - sWB_LD.
  - PCSrc is 00 in all of these except as listed below.
- j: PCSrc = 11.
- jr: PCSrc = 10.
- jal: PCSrc = 11, RegWre = 1, RegDst = 00, WrRegDSrc = 0.
- ALU group, in sEXE_AL and sWB_AL:
  - ALUSrcB = 1 for addiu, andi, ori and slti.
  - ALUSrcA = 1 for sll.
  - ExtSel = 0 for andi and ori, 1 otherwise.
  - ALUOp per instruction.
  - In sWB_AL: RegWre = 1, WrRegDSrc = 1, RegDst = 10 for R-type and 01 for immediate instructions.
- Branches in sEXE_BR: ALUOp = sub, ExtSel = 1.
  - PCSrc = 01 when taken: beq on zero = 1, bne on zero = 0, bltz on sign = 1 (rt field is $0). Otherwise PCSrc = 00.
- lw / sw: in sEXE_LS and sMEM, ALUSrcB = 1, ExtSel = 1, ALUOp = add.
  - sMEM: mWR = 1 for sw, mRD = 1 for lw.
  - sWB_LD: mRD = 1, DBDataSrc = 1, RegWre = 1, RegDst = 01, WrRegDSrc = 1.
- halt in ID:
  - sets halted and returns to sIF with PCWre = 0;
  - while halted, the state is held at sIF and all enables are 0 (IRWre, InsMemRW, PCWre, RegWre, mWR);
  - only RST clears halted.
- Illegal opcode: ID asserts illegal = 1 and PCWre = 1 with PCSrc = 00, making it a 2-cycle nop.

## Timing
- Reset at any state, including mid-instruction: the next edge gives state = sIF and halted = 0.
- While RST = 1, PCWre, IRWre, RegWre, mWR and mRD are forced to 0. All selects are 0.
- Cycles per instruction: ALU 4, lw 5, sw 4, branch 3, j/jr/jal/illegal 2.
- PC, IR, the register file and memory are written on the rising edge that ends the asserting state.
- zero and sign are sampled combinationally within sEXE_BR. The datapath must settle them within that cycle.

## Configuration
- CTRL_JAL_JR_EN defined: jal and jr are decoded as above.
- CTRL_JAL_JR_EN undefined: opcodes 111001 and 111010 are illegal (2-cycle nop with illegal = 1). RegDst 00, WrRegDSrc 0 and PCSrc 10 are never produced.

## Test plan
- RST high for 2 edges from sMEM → state = 000, halted = 0, all enables 0 during reset. Then the first IF has IRWre = 1.
- opcode add (000000) → states 000, 001, 110, 111, 000. RegWre = 1 and RegDst = 10 only in 111. PCWre = 1 only in 111.
- lw (110001) → 5 states ending at 100. Asserts mRD in 011 and 100, with DBDataSrc = 1 and RegWre = 1 in 100. sw (110000) → mWR = 1 and PCWre = 1 in 011.
- beq with zero = 1 → PCSrc = 01 in 101. With zero = 0 → PCSrc = 00. bltz with sign = 1 → taken. bne with zero = 1 → not taken.
- halt (111111) → returns to 000 with halted = 1. Over 10 further edges, state stays 000 and PCWre, IRWre and RegWre stay 0. RST clears it.
- jal (111010) with macro defined → 2 cycles; ID asserts PCSrc = 11, RegDst = 00, WrRegDSrc = 0, RegWre = 1. Without the macro → illegal = 1 and PCSrc = 00.
